// File: rtl/riscv_muldiv_pkg.sv
// Shared definitions for the RISC-V M-extension multiply/divide units:
// operation encodings and the divider sequencing states.
package riscv_muldiv_pkg;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StCalc = 2'b01,
        StDone = 2'b10
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit and keep the
// trial difference when it does not go negative.
module div_step #(
    parameter int unsigned N = 32
) (
    input  logic [N-1:0] rem_i,
    input  logic         bit_i,
    input  logic [N-1:0] divisor_i,
    output logic [N-1:0] rem_o,
    output logic         q_bit_o
);

    logic [N:0] shifted;
    logic [N:0] diff;

    assign shifted = {rem_i, bit_i};
    // Subtract as an add of the inverted divisor with carry-in 1.
    assign diff    = shifted + {1'b1, ~divisor_i} + {{N{1'b0}}, 1'b1};

    // shifted < 2*divisor, so a non-negative difference never reaches bit N.
    assign q_bit_o = ~diff[N];
    assign rem_o   = q_bit_o ? diff[N-1:0] : shifted[N-1:0];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider for DIV/DIVU/REM/REMU, one quotient bit per
// cycle, with divide-by-zero and signed-overflow results produced directly.
module seq_divider
    import riscv_muldiv_pkg::*;
#(
    parameter int unsigned N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    input  logic         flush,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result
);

    localparam int unsigned CW = $clog2(N);
    localparam logic [N-1:0] MinVal = {1'b1, {(N-1){1'b0}}};
    localparam logic [N-1:0] One    = {{(N-1){1'b0}}, 1'b1};

    div_state_e   state_q, state_d;
    logic [N-1:0] rem_q, rem_d;
    logic [N-1:0] q_q, q_d;
    logic [N-1:0] dvsr_q, dvsr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic         qneg_q, qneg_d;
    logic         rneg_q, rneg_d;
    logic         is_rem_q, is_rem_d;
    logic [N-1:0] result_q, result_d;

    logic         in_signed, in_rem, a_neg, b_neg;
    logic [N-1:0] a_mag, b_mag;
    logic [N-1:0] step_rem;
    logic         step_qbit;
    logic [N-1:0] quot_fin, rem_fin;

    div_step #(
        .N(N)
    ) u_step (
        .rem_i    (rem_q),
        .bit_i    (q_q[N-1]),
        .divisor_i(dvsr_q),
        .rem_o    (step_rem),
        .q_bit_o  (step_qbit)
    );

    always_comb begin
        in_signed = (op == OP_DIV) || (op == OP_REM);
        in_rem    = (op == OP_REM) || (op == OP_REMU);
        a_neg     = in_signed && dividend[N-1];
        b_neg     = in_signed && divisor[N-1];
        a_mag     = a_neg ? (~dividend + One) : dividend;
        b_mag     = b_neg ? (~divisor + One) : divisor;
    end

    // Final values as they will stand once the last step is shifted in.
    always_comb begin
        quot_fin = {q_q[N-2:0], step_qbit};
        rem_fin  = step_rem;
        if (qneg_q) quot_fin = ~quot_fin + One;
        if (rneg_q) rem_fin = ~rem_fin + One;
    end

    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        q_d      = q_q;
        dvsr_d   = dvsr_q;
        cnt_d    = cnt_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        is_rem_d = is_rem_q;
        result_d = result_q;

        unique case (state_q)
            StIdle: begin
                if (start && !flush) begin
                    is_rem_d = in_rem;
                    qneg_d   = a_neg ^ b_neg;
                    rneg_d   = a_neg;
                    dvsr_d   = b_mag;
                    q_d      = a_mag;
                    rem_d    = '0;
                    cnt_d    = CW'(N - 1);
                    if (divisor == '0) begin
                        result_d = in_rem ? dividend : '1;
                        state_d  = StDone;
                    end else if (in_signed && dividend == MinVal && divisor == '1) begin
                        result_d = in_rem ? '0 : MinVal;
                        state_d  = StDone;
                    end else begin
                        state_d = StCalc;
                    end
                end
            end
            StCalc: begin
                if (flush) begin
                    state_d = StIdle;
                end else begin
                    rem_d = step_rem;
                    q_d   = {q_q[N-2:0], step_qbit};
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        result_d = is_rem_q ? rem_fin : quot_fin;
                        state_d  = StDone;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            rem_q    <= '0;
            q_q      <= '0;
            dvsr_q   <= '0;
            cnt_q    <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            is_rem_q <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            q_q      <= q_d;
            dvsr_q   <= dvsr_d;
            cnt_q    <= cnt_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            is_rem_q <= is_rem_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q == StCalc);
    assign done   = (state_q == StDone);
    assign result = result_q;

endmodule
